// File: rtl/timer_apb_ctrl.sv
// ============================================================================
// timer_apb_ctrl : APB slave sequencer for the 64-bit timer register file.
// Rev 1.0
// ============================================================================
`default_nettype none

module timer_apb_ctrl #(
    parameter int unsigned        WAIT_CYCLES = 0,
    parameter int unsigned        ADDR_W      = 12,
    parameter logic [ADDR_W-1:0]  MAX_ADDR    = 'h1C
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [31:0]       pwdata_i,
    input  logic [3:0]        pstrb_i,
    input  logic [31:0]       rf_rd_data_i,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic [31:0]       prdata_o,
    output logic              wr_en_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic [3:0]        strb_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int          c_wait_init_int = (WAIT_CYCLES == 0) ? 0 : int'(WAIT_CYCLES) - 1;
    localparam logic [3:0]  c_wait_init     = 4'(c_wait_init_int);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          strb_q, strb_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic                busy_q, busy_d;

    logic                w_setup;
    logic                w_setup_err;

    assign w_setup     = psel_i && !penable_i;
    // Misaligned, out of range, or a read that carries byte strobes.
    assign w_setup_err = (paddr_i[1:0] != 2'b00) ||
                         (paddr_i > MAX_ADDR) ||
                         (!pwrite_i && (pstrb_i != 4'h0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        write_d = write_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (w_setup) begin
                    addr_d  = paddr_i;
                    wdata_d = pwdata_i;
                    strb_d  = w_setup_err ? 4'h0 : pstrb_i;
                    write_d = pwrite_i;
                    err_d   = w_setup_err;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = c_wait_init;
                    end
                end
            end
            S_WAIT: begin
                if (!psel_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the next state so the registered versions line up with it.
        pready_d  = (state_d == S_DONE);
        pslverr_d = (state_d == S_DONE) && err_d;
        wr_en_d   = (state_d != S_IDLE) && write_d;
        rd_en_d   = (state_d != S_IDLE) && !write_d;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'h0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            strb_q    <= 4'h0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            write_q   <= write_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
        end
    end

    // Read data is only driven onto the bus in the completing cycle of a clean read.
    assign prdata_o  = ((state_q == S_DONE) && !write_q && !err_q) ? rf_rd_data_i : 32'h0;

    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;
    assign wr_en_o   = wr_en_q;
    assign rd_en_o   = rd_en_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign strb_o    = strb_q;
    assign busy_o    = busy_q;

endmodule

`default_nettype wire
